pong_game_ctrl: RTL and testbench

Top-level game sequencer for the pong design. Generates the per-frame strobes: `input_enable` for the two paddle input blocks and `ball_enable` for the ball block. Runs the game state machine (idle, serve, play, point, game over) and keeps both players' scores. It consumes edge-miss events from the ball block and drives ball reset and serve direction.

---
 rtl/pong_game_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: per-frame strobes, game state machine and score keeping.
// Optional feature PONG_PAUSE_EN adds a `pause` input and a PAUSED state.
module pong_game_ctrl #(
    parameter int unsigned FRAME_DIV    = 416667,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
`ifdef PONG_PAUSE_EN
    input  logic       pause,
`endif
    output logic       input_enable,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] p1score,
    output logic [3:0] p2score,
    output logic [2:0] state,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned FW   = $clog2(FRAME_DIV);
    localparam int unsigned WMAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned WW   = $clog2(WMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_POINT  = 3'd3,
`ifdef PONG_PAUSE_EN
        ST_PAUSED = 3'd5,
`endif
        ST_OVER   = 3'd4
    } state_t;

    state_t         state_q;
    logic [FW-1:0]  frame_cnt_q;
    logic [WW-1:0]  wait_cnt_q;
    logic [3:0]     p1score_q;
    logic [3:0]     p2score_q;
    logic           input_enable_q;
    logic           ball_enable_q;
    logic           ball_reset_q;
    logic           serve_dir_q;
    logic           game_over_q;
    logic           winner_q;
`ifdef PONG_PAUSE_EN
    logic           pause_q;
    logic           pause_rise;
    assign pause_rise = pause && !pause_q;
`endif

    logic       frame_tick;
    logic [3:0] p1_inc;
    logic [3:0] p2_inc;

    assign frame_tick = (frame_cnt_q == FW'(FRAME_DIV - 1));

    // Saturating score increments
    assign p1_inc = (p1score_q >= 4'(WIN_SCORE)) ? 4'(WIN_SCORE) : p1score_q + 4'd1;
    assign p2_inc = (p2score_q >= 4'(WIN_SCORE)) ? 4'(WIN_SCORE) : p2score_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            frame_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            p1score_q      <= '0;
            p2score_q      <= '0;
            input_enable_q <= 1'b0;
            ball_enable_q  <= 1'b0;
            ball_reset_q   <= 1'b1;
            serve_dir_q    <= 1'b1;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
`ifdef PONG_PAUSE_EN
            pause_q        <= 1'b0;
`endif
        end else begin
            frame_cnt_q    <= frame_tick ? '0 : frame_cnt_q + FW'(1);
            input_enable_q <= frame_tick && ((state_q == ST_SERVE) || (state_q == ST_PLAY));
            ball_enable_q  <= frame_tick && (state_q == ST_PLAY);
`ifdef PONG_PAUSE_EN
            pause_q        <= pause;
`endif
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_q      <= ST_SERVE;
                        wait_cnt_q   <= '0;
                        p1score_q    <= '0;
                        p2score_q    <= '0;
                        serve_dir_q  <= 1'b1;
                        game_over_q  <= 1'b0;
                        ball_reset_q <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (wait_cnt_q == WW'(SERVE_FRAMES - 1)) begin
                            state_q      <= ST_PLAY;
                            wait_cnt_q   <= '0;
                            ball_reset_q <= 1'b0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WW'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    // Simultaneous misses are a dead ball: re-serve with no score change
                    if (miss_left && miss_right) begin
                        state_q      <= ST_SERVE;
                        wait_cnt_q   <= '0;
                        ball_reset_q <= 1'b1;
                    end else if (miss_left) begin
                        p2score_q    <= p2_inc;
                        serve_dir_q  <= 1'b0;
                        wait_cnt_q   <= '0;
                        ball_reset_q <= 1'b1;
                        if (p2_inc == 4'(WIN_SCORE)) begin
                            state_q     <= ST_OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= 1'b1;
                        end else begin
                            state_q <= ST_POINT;
                        end
                    end else if (miss_right) begin
                        p1score_q    <= p1_inc;
                        serve_dir_q  <= 1'b1;
                        wait_cnt_q   <= '0;
                        ball_reset_q <= 1'b1;
                        if (p1_inc == 4'(WIN_SCORE)) begin
                            state_q     <= ST_OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= 1'b0;
                        end else begin
                            state_q <= ST_POINT;
                        end
                    end
`ifdef PONG_PAUSE_EN
                    else if (pause_rise) begin
                        state_q    <= ST_PAUSED;
                        wait_cnt_q <= '0;
                    end
`endif
                end
                ST_POINT: begin
                    if (frame_tick) begin
                        if (wait_cnt_q == WW'(POINT_FRAMES - 1)) begin
                            state_q    <= ST_SERVE;
                            wait_cnt_q <= '0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WW'(1);
                        end
                    end
                end
`ifdef PONG_PAUSE_EN
                ST_PAUSED: begin
                    if (pause_rise) begin
                        state_q    <= ST_PLAY;
                        wait_cnt_q <= '0;
                    end
                end
`endif
                default: begin
                    state_q      <= ST_IDLE;
                    wait_cnt_q   <= '0;
                    ball_reset_q <= 1'b1;
                    game_over_q  <= 1'b0;
                end
            endcase
        end
    end

    assign input_enable = input_enable_q;
    assign ball_enable  = ball_enable_q;
    assign ball_reset   = ball_reset_q;
    assign serve_dir    = serve_dir_q;
    assign p1score      = p1score_q;
    assign p2score      = p2score_q;
    assign state        = state_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a frame-level reference model queues the
// expected outputs each cycle and a monitor compares them against the DUT.
module tb_pong_game_ctrl;

    localparam int FD = 4;
    localparam int SF = 2;
    localparam int PF = 2;
    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       input_enable;
    logic       ball_enable;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] p1score;
    logic [3:0] p2score;
    logic [2:0] state;
    logic       game_over;
    logic       winner;
`ifdef PONG_PAUSE_EN
    logic       pause = 1'b0;
`endif

    pong_game_ctrl #(
        .FRAME_DIV(FD), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .miss_left(miss_left), .miss_right(miss_right),
`ifdef PONG_PAUSE_EN
        .pause(pause),
`endif
        .input_enable(input_enable), .ball_enable(ball_enable),
        .ball_reset(ball_reset), .serve_dir(serve_dir),
        .p1score(p1score), .p2score(p2score), .state(state),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ie, be, br, sd, go, win;
        logic [3:0] p1, p2;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_state = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: game rules expressed as a cycle phase and frames-remaining countdown
    initial begin
        int phase = 0;
        int left = 0;
        int p1 = 0, p2 = 0;
        bit tick;
        exp_t e;
        e.ie = 0; e.be = 0; e.br = 1; e.sd = 1; e.go = 0; e.win = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                phase = 0; left = 0; p1 = 0; p2 = 0; m_state = 0;
                e.ie = 0; e.be = 0; e.br = 1; e.sd = 1; e.go = 0; e.win = 0;
            end else begin
                tick  = (phase == FD - 1);
                phase = (phase + 1) % FD;
                e.ie  = tick && (m_state == 1 || m_state == 2);
                e.be  = tick && (m_state == 2);
                case (m_state)
                    0, 4: if (start) begin
                        m_state = 1; left = SF; p1 = 0; p2 = 0; e.sd = 1; e.go = 0;
                    end
                    1: if (tick) begin
                        left--;
                        if (left == 0) m_state = 2;
                    end
                    3: if (tick) begin
                        left--;
                        if (left == 0) begin m_state = 1; left = SF; end
                    end
                    2: begin
                        if (miss_left && miss_right) begin
                            m_state = 1; left = SF;
                        end else if (miss_left) begin
                            p2 = (p2 < WS) ? p2 + 1 : WS;
                            e.sd = 0;
                            if (p2 == WS) begin m_state = 4; e.go = 1; e.win = 1; end
                            else begin m_state = 3; left = PF; end
                        end else if (miss_right) begin
                            p1 = (p1 < WS) ? p1 + 1 : WS;
                            e.sd = 1;
                            if (p1 == WS) begin m_state = 4; e.go = 1; e.win = 0; end
                            else begin m_state = 3; left = PF; end
                        end
                    end
                    default: m_state = 0;
                endcase
                e.br = (m_state != 2);
            end
            e.p1 = 4'(p1);
            e.p2 = 4'(p2);
            e.st = 3'(m_state);
            exp_q.push_back(e);
        end
    end

    // Monitor: one expected record per clock, compared away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",        int'(state),        int'(e.st));
                chk("p1score",      int'(p1score),      int'(e.p1));
                chk("p2score",      int'(p2score),      int'(e.p2));
                chk("input_enable", int'(input_enable), int'(e.ie));
                chk("ball_enable",  int'(ball_enable),  int'(e.be));
                chk("ball_reset",   int'(ball_reset),   int'(e.br));
                chk("serve_dir",    int'(serve_dir),    int'(e.sd));
                chk("game_over",    int'(game_over),    int'(e.go));
                if (e.go) chk("winner", int'(winner), int'(e.win));
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit ml, input bit mr);
        @(negedge clk);
        #1;
        rst = r; start = s; miss_left = ml; miss_right = mr;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    // Bounded wait for the DUT to reach a state; a timeout counts as a failure
    task automatic wait_state(input int st, input int budget);
        int n = 0;
        while (int'(state) != st && n < budget) begin
            step(0, 0, 0, 0);
            n++;
        end
        checks++;
        if (int'(state) != st) begin
            errors++;
            $display("FAIL wait_state: state %0d, wanted %0d within %0d cycles", state, st, budget);
        end
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(20);
        // Serve then play; observe strobe cadence
        step(0, 1, 0, 0);
        wait_state(2, 40);
        idle(9);
        // Player 1 scores
        step(0, 0, 0, 1);
        idle(1);
        wait_state(2, 60);
        // Player 2 scores three times and wins
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0);
            idle(1);
            if (k < 2) wait_state(2, 60);
        end
        idle(3);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 1);
            step(0, 0, 0, 1);
            step(0, 0, 1, 0);
        end
        step(0, 1, 0, 0);
        wait_state(2, 40);
        // Dead ball: both misses in one cycle
        step(0, 0, 1, 1);
        idle(1);
        wait_state(2, 40);
        // Reset during POINT with p1score=2
        step(0, 0, 0, 1);
        idle(1);
        wait_state(2, 60);
        step(0, 0, 0, 1);
        idle(2);
        step(1, 0, 0, 0);
        idle(12);
        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0));
        end
        idle(4);
        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
